// File: rtl/mbgd_pkg.sv
// ---------------------------------------------------------------------------
// mbgd_pkg
// Shared constants and types for the mini-batch gradient-descent multiply
// stage. The defaults here give one row of N feature*weight products, each
// kept at its full DW1+DW2 width.
//
// Contents:
//   N_DEF / N_BIT_DEF      default products per row and element-counter width
//   DW1_DEF / DW2_DEF      default feature and weight operand widths
//   PW_DEF                 default product width (DW1_DEF + DW2_DEF)
//   state_t                row-collection FSM states
// ---------------------------------------------------------------------------
package mbgd_pkg;

   localparam int N_DEF     = 8;
   localparam int N_BIT_DEF = 3;
   localparam int DW1_DEF   = 8;
   localparam int DW2_DEF   = 8;
   localparam int PW_DEF    = DW1_DEF + DW2_DEF;

   // COLLECT gathers elements into the row, HOLD presents the finished row.
   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/mbgd_mul_elem.sv
// ---------------------------------------------------------------------------
// mbgd_mul_elem
// Single combinational multiplier producing the full-width product of one
// feature element and one weight element.
//
// Build option:
//   MBGD_MUL_SIGNED_EN  defined   -> operands are two's-complement signed
//                       undefined -> operands are unsigned (default)
//
// Ports:
//   x  [DW1-1:0]      feature operand
//   w  [DW2-1:0]      weight operand
//   p  [DW1+DW2-1:0]  product, never truncated
// ---------------------------------------------------------------------------
module mbgd_mul_elem #(
   parameter int DW1 = 8,
   parameter int DW2 = 8
) (
   input  logic [DW1-1:0]     x,
   input  logic [DW2-1:0]     w,
   output logic [DW1+DW2-1:0] p
);

   logic [DW1+DW2-1:0] x_ext;
   logic [DW1+DW2-1:0] w_ext;

   // Both operands are widened to the product width before multiplying, so
   // the low DW1+DW2 bits of the product are exact. Sign extension gives the
   // correct two's-complement product; zero extension the unsigned one.
`ifdef MBGD_MUL_SIGNED_EN
   assign x_ext = {{DW2{x[DW1-1]}}, x};
   assign w_ext = {{DW1{w[DW2-1]}}, w};
`else
   assign x_ext = {{DW2{1'b0}}, x};
   assign w_ext = {{DW1{1'b0}}, w};
`endif

   assign p = x_ext * w_ext;

endmodule

// File: rtl/mbgd_mul_calc.sv
// ---------------------------------------------------------------------------
// mbgd_mul_calc
// Collects N feature/weight element pairs, multiplies each pair as it arrives
// and stores the product in its own slot. Once the row is full it is held on
// dot_products (out_valid=1) until the downstream adder accepts it.
//
// Build option:
//   MBGD_MUL_SIGNED_EN  selects signed operands (see mbgd_mul_elem)
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   flush                synchronous abort of any partial or held row
//   in_valid / in_ready  element handshake, x_in and w_in carry the element
//   out_valid / out_ready row handshake, out_valid drives the adder enable
//   dot_products         packed products, slot k in bits [(k+1)PW-1 : k*PW]
//   rows_done            number of rows handed off, wraps at 16 bits
// ---------------------------------------------------------------------------
module mbgd_mul_calc
   import mbgd_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int N_bit = N_BIT_DEF,
   parameter int DW1   = DW1_DEF,
   parameter int DW2   = DW2_DEF
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DW1-1:0]           x_in,
   input  logic [DW2-1:0]           w_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [(DW1+DW2)*N-1:0]   dot_products,
   output logic [15:0]              rows_done
);

   localparam int PW = DW1 + DW2;

   state_t              state_q, state_d;
   logic [N_bit-1:0]    cnt_q, cnt_d;
   logic [PW*N-1:0]     dot_q, dot_d;
   logic [15:0]         rows_q, rows_d;
   logic [PW-1:0]       prod;

   mbgd_mul_elem #(
      .DW1 (DW1),
      .DW2 (DW2)
   ) u_mul (
      .x (x_in),
      .w (w_in),
      .p (prod)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         dot_q   <= '0;
         rows_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dot_q   <= dot_d;
         rows_q  <= rows_d;
      end
   end

   // Flush wins over both an accept and a handoff in the same cycle, so a
   // flushed element is never written and a flushed row is never counted.
   // Slots are not cleared between rows; out_valid alone qualifies them.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dot_d   = dot_q;
      rows_d  = rows_q;

      if (flush) begin
         state_d = COLLECT;
         cnt_d   = '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (in_valid) begin
                  for (int k = 0; k < N; k++) begin
                     if (cnt_q == N_bit'(k)) begin
                        dot_d[k*PW +: PW] = prod;
                     end
                  end
                  if (cnt_q == N_bit'(N - 1)) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = COLLECT;
                  rows_d  = rows_q + 16'd1;
               end
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   assign in_ready     = (state_q == COLLECT);
   assign out_valid    = (state_q == HOLD);
   assign dot_products = dot_q;
   assign rows_done    = rows_q;

endmodule

// File: doc/mbgd_mul_calc.md
MBGD_MUL_CALC -- requirements
Module: mbgd_mul_calc

Interface
REQ-001 SHALL have parameter N, default 8: number of products per row.
REQ-002 SHALL have parameter N_bit, default 3: width of the element counter, clog2(N).
REQ-003 SHALL have parameter DW1, default 8: feature operand width.
REQ-004 SHALL have parameter DW2, default 8: weight operand width.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1: synchronous abort of any partial or held row.
REQ-008 SHALL have port in_valid, input, 1: x_in/w_in carry an element.
REQ-009 SHALL have port in_ready, output, 1: block accepts an element this cycle.
REQ-010 SHALL have port x_in, input, DW1: feature element.
REQ-011 SHALL have port w_in, input, DW2: weight element.
REQ-012 SHALL have port out_valid, output, 1: dot_products holds a complete row; drives the adder's enable.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the row.
REQ-014 SHALL have port dot_products, output, (DW1+DW2)*N: packed products; element k in bits [(k+1)(DW1+DW2)-1 : k(DW1+DW2)].
REQ-015 SHALL have port rows_done, output, 16: count of rows handed off.

Function
REQ-016 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 In COLLECT, on in_valid&in_ready, SHALL register x_in*w_in into slot cnt and increment cnt.
REQ-018 Product SHALL be the full DW1+DW2-bit result with no truncation; unsigned by default.
REQ-019 An accept with cnt==N-1 SHALL write slot N-1, clear cnt to 0 and enter HOLD on the same edge; out_valid rises the next cycle.
REQ-020 Latency SHALL be 1 cycle from the last accepted element to out_valid=1.
REQ-021 In HOLD, dot_products SHALL stay stable until out_valid&out_ready.
REQ-022 On out_valid&out_ready, SHALL return to COLLECT and increment rows_done; rows_done wraps 0xFFFF->0.
REQ-023 Slots not yet overwritten in a new row SHALL keep old values; only out_valid qualifies dot_products.
REQ-024 in_valid while in_ready=0 SHALL be ignored; the element is not consumed.
REQ-025 flush SHALL clear cnt, force COLLECT and deassert out_valid next cycle, and leave rows_done unchanged; flush has priority over accept and handoff in the same cycle.
REQ-026 in_valid held low SHALL stall the row indefinitely with cnt preserved.

Reset
REQ-027 While resetn=0: state=COLLECT, cnt=0, out_valid=0, in_ready=1 after release, dot_products=0, rows_done=0.
REQ-028 Reset mid-row or in HOLD SHALL discard the row without a handoff.

Configuration
REQ-029 Macro MBGD_MUL_SIGNED_EN defined: operands and products SHALL be two's-complement signed, with the product in DW1+DW2 bits.
REQ-030 Macro MBGD_MUL_SIGNED_EN undefined: operands and products SHALL be unsigned; there is no other behavioural difference.

Structure
REQ-031 Shared package mbgd_pkg SHALL hold the default N/N_bit/DW1/DW2 constants, the product width DW1+DW2, and the FSM state typedef.
REQ-032 One sub-module, mbgd_mul_elem, SHALL implement the single combinational multiply, including the signed/unsigned selection.

Verification
REQ-033 Bench: elements x=1..8, w=2 back-to-back, out_ready=1 -> out_valid 1 cycle after 8th accept; slots = 2,4,..,16; adder sum 72; rows_done=1.
REQ-034 Bench: x=255, w=255 for all 8 elements -> each slot 16'hFE01, no overflow.
REQ-035 Bench: row complete, out_ready=0 for 5 cycles -> out_valid stays 1, in_ready stays 0, dot_products stable, in_valid ignored; handoff on the first out_ready.
REQ-036 Bench: flush after 3 elements, then 8 new elements -> only the new row is delivered, rows_done +1.
REQ-037 Bench: resetn pulsed low in HOLD -> out_valid=0, dot_products=0, rows_done=0 immediately.
REQ-038 Bench: MBGD_MUL_SIGNED_EN defined, x=-3 (8'hFD), w=5 -> slot = 16'hFFF1 (-15).
